dpcm_arbiter: RTL and testbench
===============================

DPCM_ARBITER -- requirements
Module: dpcm_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of requesting sample channels (2..8).
REQ-002 Parameter W, default 8, sample and difference width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 Valid  input  NCH  per-channel sample-valid request.
REQ-006 DataIn  input  NCH*W  packed per-channel samples; channel i occupies bits [i*W +: W].
REQ-007 Ready  output  NCH  per-channel accept strobe; a sample transfers when Valid[i] && Ready[i].
REQ-008 DataOut  output  W  absolute difference of the accepted sample and that channel's previous sample.
REQ-009 OutValid  output  1  DataOut/OutChan valid.
REQ-010 OutChan  output  $clog2(NCH)  channel index of the current result.
REQ-011 OutReady  input  1  downstream accepts the result when OutValid && OutReady.

Function
REQ-012 States: IDLE, COMPUTE, HOLD.
REQ-013 IDLE: Ready is combinational and one-hot at most: Ready[g]=1 only for the grant g, the first i with Valid[i]=1 searching upward from pointer ptr with wrap NCH-1->0; Ready=0 when no Valid is set or the state is not IDLE.
REQ-014 IDLE with a transfer: latch DataIn[g] into cur, g into gsel, then go to COMPUTE; with no Valid, stay in IDLE.
REQ-015 COMPUTE (one cycle): DataOut <= |cur - prev[gsel]| (larger minus smaller, W bits, no wrap), prev[gsel] <= cur, OutChan <= gsel, OutValid <= 1, then go to HOLD.
REQ-016 HOLD: DataOut, OutChan and OutValid hold stable while OutReady=0; on OutReady=1, OutValid <= 0, ptr <= gsel+1 (wrap to 0 after NCH-1), then go to IDLE.
REQ-017 Latency: a transfer in cycle N gives OutValid=1 from cycle N+2; minimum 3 cycles per sample.
REQ-018 Fairness: a continuously requesting channel is served within NCH grants.
REQ-019 Equal samples produce DataOut=0; a channel's first sample after reset is differenced against 0.
REQ-020 A Valid dropped in IDLE before transfer is not latched; there is no state change for it.
REQ-021 prev[] of non-granted channels never change.
REQ-022 Valid[i] asserted while not in IDLE is held off (Ready[i]=0) and is not lost if it is held.

Reset
REQ-023 rst=1 forces the following immediately, independent of clk: state=IDLE, ptr=0, gsel=0, cur=0, all prev[]=0, DataOut=0, OutChan=0, OutValid=0.
REQ-024 Reset mid-operation (COMPUTE or HOLD) discards the pending sample/result without emitting it.
REQ-025 First grant after reset release goes to the lowest-index requesting channel.

Structure
REQ-026 Package dpcm_pkg holds the state enum (IDLE, COMPUTE, HOLD) and default constants DPCM_NCH=4 and DPCM_W=8.
REQ-027 A combinational sub-module dpcm_abs_diff (inputs a, b; output |a-b|, width W) performs the difference; the arbiter, pointer and prev[] storage stay in dpcm_arbiter.

Verification
REQ-028 Reset, then Valid=4'b0001, DataIn[0]=8'd30, OutReady=1 -> Ready=4'b0001 in cycle N, OutValid=1 at N+2, DataOut=30, OutChan=0.
REQ-029 Channel 0 sends 30 then 10 -> second DataOut=20; then 10 again -> DataOut=0.
REQ-030 Valid=4'b1111 held continuously with OutReady=1 -> OutChan sequence 0,1,2,3,0; each channel's prev[] updates independently.
REQ-031 OutReady=0 for 5 cycles in HOLD -> DataOut/OutChan stable, OutValid=1, Ready=0; release -> one result only, ptr advanced.
REQ-032 Assert rst during HOLD -> OutValid=0 at once without a clock edge; after release, channel 2 sample 8'd5 -> DataOut=5 (prev cleared).
REQ-033 Channel 1 at 8'd200 then 8'd50 -> DataOut=150; channel 1 at 8'd0 then 8'd255 -> DataOut=255 (no wrap).

Source files
------------

// File: rtl/dpcm_pkg.sv
// Shared definitions for the DPCM arbiter: FSM state encoding and default sizing.
// Ports: none (package only).
// Imported by dpcm_arbiter and dpcm_abs_diff.
package dpcm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int DPCM_NCH = 4;
    localparam int DPCM_W   = 8;

endpackage

// File: rtl/dpcm_abs_diff.sv
// Purpose: combinational absolute difference |a - b| without wrap-around.
// Ports: a, b (W-bit unsigned operands), y (W-bit result).
// Latency: zero cycles; no flow control.
module dpcm_abs_diff
    import dpcm_pkg::*;
#(
    parameter int W = DPCM_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Subtract the smaller from the larger so the result never wraps.
    assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/dpcm_arbiter.sv
// Purpose: round-robin arbiter over NCH sample channels; emits |sample - previous sample| per channel.
// Ports: clk, rst (async active-high), Valid/DataIn/Ready per channel; DataOut/OutChan/OutValid/OutReady result side.
// Latency: transfer in cycle N gives OutValid in N+2; result held until OutReady; Ready only offered in IDLE.
module dpcm_arbiter
    import dpcm_pkg::*;
#(
    parameter int NCH = DPCM_NCH,
    parameter int W   = DPCM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         Valid,
    input  logic [NCH*W-1:0]       DataIn,
    output logic [NCH-1:0]         Ready,
    output logic [W-1:0]           DataOut,
    output logic                   OutValid,
    output logic [$clog2(NCH)-1:0] OutChan,
    input  logic                   OutReady
);

    localparam int CW = $clog2(NCH);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  gsel;
    logic [W-1:0]   cur;
    logic [W-1:0]   prev [NCH];
    logic [CW-1:0]  grant;
    logic           found;
    logic           xfer;
    logic [W-1:0]   diff;

    // Rotating priority search: first requester at or above ptr, wrapping to 0.
    always_comb begin
        logic [CW-1:0] cand;
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = CW'((int'(ptr) + k) % NCH);
            if (!found && Valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        Ready = '0;
        if (state == IDLE && found) begin
            Ready[grant] = 1'b1;
        end
    end

    assign xfer = (state == IDLE) && found;

    dpcm_abs_diff #(.W(W)) u_abs_diff (
        .a (cur),
        .b (prev[gsel]),
        .y (diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = COMPUTE;
            COMPUTE: state_nxt = HOLD;
            HOLD:    if (OutReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            gsel     <= '0;
            cur      <= '0;
            DataOut  <= '0;
            OutChan  <= '0;
            OutValid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                prev[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cur  <= DataIn[int'(grant)*W +: W];
                        gsel <= grant;
                    end
                end
                COMPUTE: begin
                    DataOut    <= diff;
                    prev[gsel] <= cur;
                    OutChan    <= gsel;
                    OutValid   <= 1'b1;
                end
                HOLD: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        // Next search starts just past the channel just served.
                        ptr      <= (gsel == CW'(NCH - 1)) ? '0 : gsel + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpcm_arbiter.sv
// Directed self-checking bench for dpcm_arbiter (NCH=4, W=8).
// Inputs are driven on the falling edge, outputs sampled on the falling edge or just after.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_dpcm_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  Valid;
    logic [31:0] DataIn;
    logic [3:0]  Ready;
    logic [7:0]  DataOut;
    logic        OutValid;
    logic [1:0]  OutChan;
    logic        OutReady;

    int checks;
    int failures;

    dpcm_arbiter #(.NCH(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .Valid    (Valid),
        .DataIn   (DataIn),
        .Ready    (Ready),
        .DataOut  (DataOut),
        .OutValid (OutValid),
        .OutChan  (OutChan),
        .OutReady (OutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-channel transaction with OutReady=1; returns the emitted result.
    task automatic send(input int ch, input logic [7:0] val,
                        output logic [7:0] d, output logic [1:0] c);
        bit ok;
        ok = 1'b0;
        d  = '0;
        c  = '0;
        @(negedge clk);
        OutReady = 1'b1;
        DataIn[ch*8 +: 8] = val;
        Valid = '0;
        Valid[ch] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Valid = '0;
        for (int t = 0; t < 10; t++) begin
            if (OutValid) begin
                ok = 1'b1;
                d  = DataOut;
                c  = OutChan;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: ch=%0d no OutValid within 10 cycles", ch);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Valid = '0; DataIn = '0; OutReady = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid: got %0b want 0", OutValid); end
        checks++; if (DataOut !== 8'd0) begin failures++; $display("FAIL reset_dataout: got %0d want 0", DataOut); end
        checks++; if (OutChan !== 2'd0) begin failures++; $display("FAIL reset_outchan: got %0d want 0", OutChan); end
        checks++; if (Ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", Ready); end
        rst = 1'b0;
    endtask

    task automatic test_first_latency();
        @(negedge clk);
        Valid = 4'b0001; DataIn[7:0] = 8'd30; OutReady = 1'b1;
        #1;
        checks++; if (Ready !== 4'b0001) begin failures++; $display("FAIL first_ready: got %b want 0001", Ready); end
        @(posedge clk);
        @(negedge clk);
        Valid = '0;
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL first_n1_outvalid: got %0b want 0", OutValid); end
        @(negedge clk);
        checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL first_n2_outvalid: got %0b want 1", OutValid); end
        checks++; if (DataOut !== 8'd30) begin failures++; $display("FAIL first_dataout: got %0d want 30", DataOut); end
        checks++; if (OutChan !== 2'd0) begin failures++; $display("FAIL first_outchan: got %0d want 0", OutChan); end
    endtask

    task automatic test_same_channel();
        logic [7:0] d;
        logic [1:0] c;
        send(0, 8'd10, d, c);
        checks++; if (d !== 8'd20) begin failures++; $display("FAIL ch0_30_to_10: got %0d want 20", d); end
        send(0, 8'd10, d, c);
        checks++; if (d !== 8'd0) begin failures++; $display("FAIL ch0_equal: got %0d want 0", d); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_c [5];
        logic [7:0] exp_d [5];
        bit seen;
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{8'd5, 8'd10, 8'd15, 8'd20, 8'd20};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        OutReady = 1'b1;
        DataIn = {8'd20, 8'd15, 8'd10, 8'd5};
        Valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 12; t++) begin
                if (OutValid) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!seen) begin
                failures++; $display("FAIL rr_timeout: result %0d missing", k);
            end else begin
                checks++; if (OutChan !== exp_c[k]) begin failures++; $display("FAIL rr_chan%0d: got %0d want %0d", k, OutChan, exp_c[k]); end
                checks++; if (DataOut !== exp_d[k]) begin failures++; $display("FAIL rr_data%0d: got %0d want %0d", k, DataOut, exp_d[k]); end
                checks++; if (Ready !== 4'b0000) begin failures++; $display("FAIL rr_ready_hold%0d: got %b want 0000", k, Ready); end
            end
            if (k == 0) DataIn[7:0] = 8'd25;
            if (k == 4) Valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        bit seen;
        // ptr=1 here; ch3 holds prev=20.
        @(negedge clk);
        OutReady = 1'b0;
        Valid = 4'b1000; DataIn[31:24] = 8'd100;
        @(posedge clk);
        @(negedge clk);
        // Request from ch1 while busy: must be held off, not lost.
        Valid = 4'b0010; DataIn[15:8] = 8'd40;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (OutValid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL hold_timeout: no OutValid"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL hold_outvalid%0d: got %0b want 1", i, OutValid); end
            checks++; if (DataOut !== 8'd80) begin failures++; $display("FAIL hold_data%0d: got %0d want 80", i, DataOut); end
            checks++; if (OutChan !== 2'd3) begin failures++; $display("FAIL hold_chan%0d: got %0d want 3", i, OutChan); end
            checks++; if (Ready !== 4'b0000) begin failures++; $display("FAIL hold_ready%0d: got %b want 0000", i, Ready); end
            @(negedge clk);
        end
        OutReady = 1'b1;
        Valid = 4'b0011;
        @(negedge clk);
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL hold_release_outvalid: got %0b want 0", OutValid); end
        // ptr wrapped 3 -> 0, so ch0 wins over ch1.
        checks++; if (Ready !== 4'b0001) begin failures++; $display("FAIL hold_ptr_wrap_ready: got %b want 0001", Ready); end
        #1;
        Valid = 4'b0010;
        #1;
        checks++; if (Ready !== 4'b0010) begin failures++; $display("FAIL dropped_valid_ready: got %b want 0010", Ready); end
        @(posedge clk);
        @(negedge clk);
        Valid = '0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (OutValid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL held_req_timeout: no OutValid"); end
        checks++; if (OutChan !== 2'd1) begin failures++; $display("FAIL held_req_chan: got %0d want 1", OutChan); end
        checks++; if (DataOut !== 8'd30) begin failures++; $display("FAIL held_req_data: got %0d want 30", DataOut); end
        @(negedge clk);
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL single_result: got %0b want 0", OutValid); end
    endtask

    task automatic test_reset_in_hold();
        bit seen;
        @(negedge clk);
        OutReady = 1'b0;
        Valid = 4'b0100; DataIn[23:16] = 8'd50;
        @(posedge clk);
        @(negedge clk);
        Valid = '0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (OutValid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rsthold_timeout: no OutValid"); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL async_rst_outvalid: got %0b want 0", OutValid); end
        checks++; if (DataOut !== 8'd0) begin failures++; $display("FAIL async_rst_dataout: got %0d want 0", DataOut); end
        @(negedge clk);
        rst = 1'b0;
        OutReady = 1'b1;
        Valid = 4'b0110; DataIn[15:8] = 8'd77; DataIn[23:16] = 8'd5;
        #1;
        checks++; if (Ready !== 4'b0010) begin failures++; $display("FAIL post_rst_lowest: got %b want 0010", Ready); end
        Valid = 4'b0100;
        #1;
        checks++; if (Ready !== 4'b0100) begin failures++; $display("FAIL post_rst_ch2_ready: got %b want 0100", Ready); end
        @(posedge clk);
        @(negedge clk);
        Valid = '0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (OutValid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL post_rst_timeout: no OutValid"); end
        checks++; if (DataOut !== 8'd5) begin failures++; $display("FAIL post_rst_prev_cleared: got %0d want 5", DataOut); end
        checks++; if (OutChan !== 2'd2) begin failures++; $display("FAIL post_rst_chan: got %0d want 2", OutChan); end
    endtask

    task automatic test_no_wrap();
        logic [7:0] d;
        logic [1:0] c;
        send(1, 8'd200, d, c);
        checks++; if (d !== 8'd200) begin failures++; $display("FAIL ch1_first: got %0d want 200", d); end
        checks++; if (c !== 2'd1) begin failures++; $display("FAIL ch1_chan: got %0d want 1", c); end
        send(1, 8'd50, d, c);
        checks++; if (d !== 8'd150) begin failures++; $display("FAIL ch1_200_to_50: got %0d want 150", d); end
        send(1, 8'd0, d, c);
        checks++; if (d !== 8'd50) begin failures++; $display("FAIL ch1_50_to_0: got %0d want 50", d); end
        send(1, 8'd255, d, c);
        checks++; if (d !== 8'd255) begin failures++; $display("FAIL ch1_0_to_255: got %0d want 255", d); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_latency();
        test_same_channel();
        test_round_robin();
        test_hold();
        test_reset_in_hold();
        test_no_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
